// File: rtl/regarb_pkg.sv
// regfile_write_arbiter shared types and sizes.
// Optional init sequencer is enabled by REGARB_INIT_EN.
package regarb_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_COUNT  = 16;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  // r0 is hardwired to zero, so writes to it are suppressed
  function automatic logic wr_en(input reg_addr_t a);
    return a != '0;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Core/external write requests and register file write port.
// Shared by regfile_write_arbiter (slave) and its requesters (master).
interface regfile_write_arbiter_if
  import regarb_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic             core_we;
  reg_addr_t        core_wa;
  logic [WIDTH-1:0] core_wd;
  logic             core_stall;

  logic             ext_req;
  reg_addr_t        ext_wa;
  logic [WIDTH-1:0] ext_wd;
  logic             ext_ack;

  logic             we3;
  reg_addr_t        wa3;
  logic [WIDTH-1:0] wd3;
  logic             busy;

  modport master (
    output core_we, core_wa, core_wd,
    output ext_req, ext_wa, ext_wd,
    input  core_stall, ext_ack,
    input  we3, wa3, wd3, busy
  );

  modport slave (
    input  core_we, core_wa, core_wd,
    input  ext_req, ext_wa, ext_wd,
    output core_stall, ext_ack,
    output we3, wa3, wd3, busy
  );

endinterface

// File: rtl/regarb_init_seq.sv
// Post-reset clear sequencer: walks r1..r15 once.
// Instantiated only when REGARB_INIT_EN is defined.
module regarb_init_seq
  import regarb_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  output logic      busy,
  output reg_addr_t idx,
  output logic      done
);

  localparam reg_addr_t LAST = reg_addr_t'(REG_COUNT - 1);

  logic active;

  assign done = active && (idx == LAST);
  assign busy = active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b1;
      idx    <= reg_addr_t'(1);
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else begin
        idx <= idx + reg_addr_t'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between core writeback and an
// external requester. REGARB_INIT_EN adds a post-reset r1..r15 clear.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic reset,
  regfile_write_arbiter_if.slave bus
);

  localparam wait_cnt_t STARVE_LIM = wait_cnt_t'(STARVE_MAX);
  localparam wait_cnt_t WAIT_SAT   = '1;
  localparam logic [WIDTH-1:0] ZERO_D = '0;

  state_t    state;
  wait_cnt_t wait_cnt;
  wait_cnt_t wait_nx;
  reg_addr_t init_idx;
  logic      init_busy;
  logic      init_on;
  logic      run;
  logic      grant_ext;
  logic      grant_core;

`ifdef REGARB_INIT_EN
  state_t state_nx;
  logic   init_done;

  regarb_init_seq u_init (
    .clk   (clk),
    .reset (reset),
    .busy  (init_busy),
    .idx   (init_idx),
    .done  (init_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT:    if (init_done) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end
`else
  assign state     = RUN;
  assign init_busy = 1'b0;
  assign init_idx  = '0;
`endif

  assign init_on  = reset && (state == INIT);
  assign run      = reset && (state == RUN);
  assign bus.busy = reset && init_busy;

  // Core wins unless ext has been denied STARVE_MAX cycles in a row
  assign grant_ext = run && bus.ext_req &&
                     (!bus.core_we || wait_cnt >= STARVE_LIM);
  assign grant_core = run && bus.core_we && !grant_ext;

  always_comb begin
    wait_nx = '0;
    if (run && bus.ext_req && !grant_ext) begin
      wait_nx = (wait_cnt == WAIT_SAT) ? wait_cnt
                : wait_cnt + wait_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= '0;
    else        wait_cnt <= wait_nx;
  end

  always_comb begin
    bus.we3        = 1'b0;
    bus.wa3        = '0;
    bus.wd3        = ZERO_D;
    bus.ext_ack    = 1'b0;
    bus.core_stall = 1'b0;
    unique case (1'b1)
      init_on: begin
        bus.we3        = 1'b1;
        bus.wa3        = init_idx;
        bus.core_stall = 1'b1;
      end
      grant_ext: begin
        bus.ext_ack    = 1'b1;
        bus.we3        = wr_en(bus.ext_wa);
        bus.wa3        = bus.ext_wa;
        bus.wd3        = bus.ext_wd;
        bus.core_stall = bus.core_we;
      end
      grant_core: begin
        bus.we3 = wr_en(bus.core_wa);
        bus.wa3 = bus.core_wa;
        bus.wd3 = bus.core_wd;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port (we3/wa3/wd3) of the 16-entry register file between the CPU core's writeback path and an external requester (I/O loader or debug port). The core has priority, but a starvation counter guarantees the external requester a slot, stalling the core for that cycle via `core_stall`. `core_stall` drives the PC register's enable and the flag flip-flop's load enable. An optional post-reset sequencer clears r1..r15 before either side is granted.

## Interface
- `WIDTH`, 8: data width of the register file.
- `STARVE_MAX`, 4: consecutive denied cycles after which the external requester wins; legal range 1..15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `core_we`  in  1  core writeback request for this cycle.
- `core_wa`  in  4  core destination register.
- `core_wd`  in  WIDTH  core write data.
- `core_stall`  out  1  core must not commit this cycle; hold PC and flags.
- `ext_req`  in  1  external write request, level; held until acked.
- `ext_wa`  in  4  external destination register; stable while `ext_req`=1.
- `ext_wd`  in  WIDTH  external write data; stable while `ext_req`=1.
- `ext_ack`  out  1  external write performed at the coming edge.
- `we3`, `wa3`, `wd3`  out  1/4/WIDTH  register file write port.
- `busy`  out  1  init sequence in progress.

## Operation
- State: `state` ∈ {INIT, RUN}, `wait_cnt` (4 bits, saturating), `init_idx` (4 bits).
- RUN arbitration is combinational from the inputs and registered `wait_cnt`:
  - only `core_we`: grant core; `we3`=1, `wa3`/`wd3` taken from the core.
  - only `ext_req`: grant ext; `ext_ack`=1 with the ext address and data.
  - both, `wait_cnt` < STARVE_MAX: grant core; `wait_cnt` increments.
  - both, `wait_cnt` >= STARVE_MAX: grant ext; `ext_ack`=1, `core_stall`=1. The core write is dropped and the core re-issues it the next cycle.
  - neither: `we3`=0, `wa3`=0, `wd3`=0.
- `wait_cnt` clears on any ext grant or when `ext_req`=0. It saturates at 15.
- A granted write to address 0 forces `we3`=0. The ack or grant is still given, so r0 stays hardwired to zero.
- `ext_req` held high after an ack is a new request the following cycle. There is one write per ack.
- `core_stall`=0 whenever the core is granted or not requesting.

## Timing
- Grant and port outputs are combinational within the request cycle. The register file write lands at the next rising edge, so the core's writeback adds zero latency.
- Ext worst-case latency with the core writing every cycle: STARVE_MAX+1 cycles from `ext_req` rise to `ext_ack`.
- While `reset`=0: `state` is INIT if configured, else RUN; `wait_cnt`=0 and `init_idx`=1. All outputs are forced low combinationally: `we3`, `wa3`, `wd3`, `ext_ack`, `core_stall`, `busy`=0.
- A reset asserted mid-operation aborts any grant immediately. An in-flight ext request is not acked; the requester keeps `ext_req` high and is served after reset.

## Configuration
- `REGARB_INIT_EN` defined:
  - After reset release the block enters INIT and writes 0 to r1..r15, one per cycle (`wa3`=`init_idx`, `we3`=1), taking 15 cycles.
  - During INIT: `busy`=1, `core_stall`=1, `ext_ack`=0, and `wait_cnt` holds at 0.
  - After writing r15 the block moves to RUN on the next edge.
- `REGARB_INIT_EN` undefined: the block starts in RUN, `busy` is tied 0, and the INIT logic is absent.

## Structure
- Shared package `regarb_pkg` holds:
  - the state encoding: INIT=1'b0, RUN=1'b1;
  - `REG_ADDR_W`=4 and `REG_COUNT`=16;
  - `WAIT_CNT_W`=4.
- One sub-module, `regarb_init_seq`, contains `init_idx`, `busy` and a done pulse. It is instantiated only under `REGARB_INIT_EN`.

## Test plan
- Core only: `core_we`=1, `core_wa`=3, `core_wd`=8'h5A -> `we3`=1, `wa3`=3, `wd3`=8'h5A, `core_stall`=0, and r3=8'h5A after the edge.
- Ext only: `ext_req`=1, `ext_wa`=7, `ext_wd`=8'hC3 -> `ext_ack`=1 the same cycle and r7=8'hC3 after the edge.
- Starvation, STARVE_MAX=4, core writes every cycle and `ext_req` is held -> core is granted for 4 cycles. On the 5th cycle `ext_ack`=1, `core_stall`=1 and the ext data is written; `wait_cnt` returns to 0.
- Address 0: `ext_req` with `ext_wa`=0 -> `ext_ack`=1, `we3`=0, and r0 still reads 0.
- Init (macro defined): release reset -> `busy`=1 for exactly 15 cycles with `wa3` stepping 1..15 and `wd3`=0. Ext is not acked until cycle 16.
- Mid-operation reset: pull `reset` low during an ext-granted cycle -> `we3`, `ext_ack` and `core_stall` drop immediately; after release, arbitration (or INIT) restarts with `wait_cnt`=0.
